// File: rtl/w_sched_pkg.sv
// Shared definitions for the weight-tile scheduler: FSM state encoding and a
// small unsigned min() helper used for edge-tile sizing.
package w_sched_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD      = 3'd1;
  localparam logic [STATE_W-1:0] S_RELEASE   = 3'd2;
  localparam logic [STATE_W-1:0] S_ADVANCE   = 3'd3;
  localparam logic [STATE_W-1:0] S_WAIT_BANK = 3'd4;
  localparam logic [STATE_W-1:0] S_DRAIN     = 3'd5;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/w_bank_tracker.sv
// Two-entry ping-pong bank tracker: full flags plus stored tile sizes, zero-latency read side.
// A set (producer) and a clear (consumer) in the same cycle always target different banks.
module w_bank_tracker #(
  parameter int SIZE_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [SIZE_W-1:0] set_col_i,
  input  logic [SIZE_W-1:0] set_row_i,
  input  logic              clr_i,
  output logic [1:0]        full_o,
  output logic              wr_ptr_o,
  output logic              rd_ptr_o,
  output logic [SIZE_W-1:0] rd_col_o,
  output logic [SIZE_W-1:0] rd_row_o
);

  logic [1:0]             full_q, full_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [1:0][SIZE_W-1:0] col_q, col_d;
  logic [1:0][SIZE_W-1:0] row_q, row_d;

  always_comb begin
    full_d = full_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    col_d  = col_q;
    row_d  = row_q;
    if (set_i) begin
      full_d[wr_q] = 1'b1;
      col_d[wr_q]  = set_col_i;
      row_d[wr_q]  = set_row_i;
      wr_d         = ~wr_q;
    end
    // Consume only ever retires a bank that is actually holding a tile.
    if (clr_i && full_q[rd_q]) begin
      full_d[rd_q] = 1'b0;
      rd_d         = ~rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 2'b00;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign full_o   = full_q;
  assign wr_ptr_o = wr_q;
  assign rd_ptr_o = rd_q;
  assign rd_col_o = col_q[rd_q];
  assign rd_row_o = row_q[rd_q];

endmodule

// File: rtl/w_tile_scheduler.sv
// Walks a weight matrix in row-major tiles, drives the w_ram generator into alternating banks
// and hands finished banks to the compute array via valid/ready; loading stalls while both banks are full.
module w_tile_scheduler #(
  parameter int INTEGER_BIT      = 7,
  parameter int W_RAM_ADDR_WIDTH = 7,
  parameter int TILE_COLS        = 8,
  parameter int TILE_ROWS        = 8,
  parameter int BANK_OFFSET      = 2 ** (W_RAM_ADDR_WIDTH - 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        ws_os,
  input  logic [INTEGER_BIT-1:0]      mat_col_size,
  input  logic [INTEGER_BIT-1:0]      mat_row_size,
  output logic                        busy,
  output logic                        done,
  output logic                        gen_enable,
  input  logic                        gen_finish,
  output logic                        gen_ws_os,
  output logic [INTEGER_BIT-1:0]      gen_col_size,
  output logic [INTEGER_BIT-1:0]      gen_row_size,
  output logic [INTEGER_BIT-1:0]      gen_bram_col_size,
  output logic [INTEGER_BIT-1:0]      gen_bram_row_size,
  output logic [INTEGER_BIT-1:0]      gen_bram_col_start_index,
  output logic [INTEGER_BIT-1:0]      gen_bram_row_start_index,
  output logic [W_RAM_ADDR_WIDTH-1:0] gen_w_ram_start_addr,
  output logic                        tile_valid,
  input  logic                        tile_ready,
  output logic                        tile_bank,
  output logic [INTEGER_BIT-1:0]      tile_col_size,
  output logic [INTEGER_BIT-1:0]      tile_row_size
);

  import w_sched_pkg::*;

  localparam int IDXW = INTEGER_BIT + 1;

  logic [STATE_W-1:0]     state_q, state_d;
  logic                   ws_os_q, ws_os_d;
  logic [INTEGER_BIT-1:0] mcol_q, mcol_d;
  logic [INTEGER_BIT-1:0] mrow_q, mrow_d;
  logic [IDXW-1:0]        col_idx_q, col_idx_d;
  logic [IDXW-1:0]        row_idx_q, row_idx_d;
  logic                   done_q, done_d;

  logic [IDXW-1:0]        mcol_ext, mrow_ext;
  logic [IDXW-1:0]        rem_col, rem_row;
  logic [IDXW-1:0]        col_sum, row_sum;
  logic                   row_wrap, last_tile;

  logic [1:0]             bank_full;
  logic                   wr_bank, rd_bank;
  logic                   load_done;

  // Indices live one bit wider than the size fields so idx+TILE never wraps.
  assign mcol_ext  = {1'b0, mcol_q};
  assign mrow_ext  = {1'b0, mrow_q};
  assign rem_col   = (col_idx_q >= mcol_ext) ? '0 : (mcol_ext - col_idx_q);
  assign rem_row   = (row_idx_q >= mrow_ext) ? '0 : (mrow_ext - row_idx_q);
  assign col_sum   = col_idx_q + IDXW'(TILE_COLS);
  assign row_sum   = row_idx_q + IDXW'(TILE_ROWS);
  assign row_wrap  = (row_sum >= mrow_ext);
  assign last_tile = row_wrap && (col_sum >= mcol_ext);

  assign gen_col_size = INTEGER_BIT'(min_u(32'(TILE_COLS), 32'(rem_col)));
  assign gen_row_size = INTEGER_BIT'(min_u(32'(TILE_ROWS), 32'(rem_row)));

  assign load_done = (state_q == S_LOAD) && gen_finish;

  always_comb begin
    state_d   = state_q;
    ws_os_d   = ws_os_q;
    mcol_d    = mcol_q;
    mrow_d    = mrow_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ws_os_d   = ws_os;
          mcol_d    = mat_col_size;
          mrow_d    = mat_row_size;
          col_idx_d = '0;
          row_idx_d = '0;
          if ((mat_col_size == '0) || (mat_row_size == '0)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT_BANK;
          end
        end
      end
      S_WAIT_BANK: begin
        if (!bank_full[wr_bank]) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (gen_finish) begin
          state_d = S_RELEASE;
        end
      end
      // One idle cycle with gen_enable low lets the generator reset its counter.
      S_RELEASE: begin
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (row_wrap) begin
          row_idx_d = '0;
          col_idx_d = col_sum;
        end else begin
          row_idx_d = row_sum;
        end
        state_d = last_tile ? S_DRAIN : S_WAIT_BANK;
      end
      S_DRAIN: begin
        if (bank_full == 2'b00) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ws_os_q   <= 1'b0;
      mcol_q    <= '0;
      mrow_q    <= '0;
      col_idx_q <= '0;
      row_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_os_q   <= ws_os_d;
      mcol_q    <= mcol_d;
      mrow_q    <= mrow_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      done_q    <= done_d;
    end
  end

  w_bank_tracker #(
    .SIZE_W (INTEGER_BIT)
  ) u_bank_tracker (
    .clk       (clk),
    .rst       (rst),
    .set_i     (load_done),
    .set_col_i (gen_col_size),
    .set_row_i (gen_row_size),
    .clr_i     (tile_ready),
    .full_o    (bank_full),
    .wr_ptr_o  (wr_bank),
    .rd_ptr_o  (rd_bank),
    .rd_col_o  (tile_col_size),
    .rd_row_o  (tile_row_size)
  );

  // Decoded straight from the async-reset state register, so rst drops it immediately.
  assign gen_enable = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

  assign gen_ws_os                = ws_os_q;
  assign gen_bram_col_size        = mcol_q;
  assign gen_bram_row_size        = mrow_q;
  assign gen_bram_col_start_index = col_idx_q[INTEGER_BIT-1:0];
  assign gen_bram_row_start_index = row_idx_q[INTEGER_BIT-1:0];
  assign gen_w_ram_start_addr     = wr_bank ? W_RAM_ADDR_WIDTH'(BANK_OFFSET) : '0;

  assign tile_valid = bank_full[rd_bank];
  assign tile_bank  = rd_bank;

endmodule

// File: tb/tb_w_tile_scheduler.sv
// Scoreboard bench for w_tile_scheduler with 4x4 tiles: stimulus pushes expected loads/tiles,
// a negedge monitor pops and compares whenever the DUT starts a load, hands over a tile or signals done.
module tb_w_tile_scheduler;

  localparam int IB = 7;
  localparam int AW = 7;

  typedef struct {
    int cs; int rs; int csz; int rsz; int bc; int br; int addr; int ws;
  } load_t;

  typedef struct {
    int bank; int csz; int rsz;
  } tile_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ws_os = 1'b0;
  logic [IB-1:0] mat_col_size = '0;
  logic [IB-1:0] mat_row_size = '0;
  logic          gen_finish = 1'b0;
  logic          tile_ready = 1'b0;

  logic          busy, done, gen_enable, gen_ws_os, tile_valid, tile_bank;
  logic [IB-1:0] gen_col_size, gen_row_size, gen_bram_col_size, gen_bram_row_size;
  logic [IB-1:0] gen_bram_col_start_index, gen_bram_row_start_index;
  logic [AW-1:0] gen_w_ram_start_addr;
  logic [IB-1:0] tile_col_size, tile_row_size;

  w_tile_scheduler #(
    .INTEGER_BIT      (IB),
    .W_RAM_ADDR_WIDTH (AW),
    .TILE_COLS        (4),
    .TILE_ROWS        (4)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .ws_os                    (ws_os),
    .mat_col_size             (mat_col_size),
    .mat_row_size             (mat_row_size),
    .busy                     (busy),
    .done                     (done),
    .gen_enable               (gen_enable),
    .gen_finish               (gen_finish),
    .gen_ws_os                (gen_ws_os),
    .gen_col_size             (gen_col_size),
    .gen_row_size             (gen_row_size),
    .gen_bram_col_size        (gen_bram_col_size),
    .gen_bram_row_size        (gen_bram_row_size),
    .gen_bram_col_start_index (gen_bram_col_start_index),
    .gen_bram_row_start_index (gen_bram_row_start_index),
    .gen_w_ram_start_addr     (gen_w_ram_start_addr),
    .tile_valid               (tile_valid),
    .tile_ready               (tile_ready),
    .tile_bank                (tile_bank),
    .tile_col_size            (tile_col_size),
    .tile_row_size            (tile_row_size)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    load_cnt = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    start_cyc = 0;
  int    gen_cnt = 0;
  logic  ge_prev = 1'b0;
  logic  done_prev = 1'b0;
  load_t exp_load[$];
  tile_t exp_tile[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: raises gen_finish on the second cycle of gen_enable, for one cycle.
  always begin
    @(posedge clk);
    #1;
    if (gen_finish) begin
      gen_finish = 1'b0;
      gen_cnt    = 0;
    end else if (gen_enable) begin
      gen_cnt++;
      if (gen_cnt >= 2) gen_finish = 1'b1;
    end else begin
      gen_cnt = 0;
    end
  end

  always @(negedge clk) begin
    load_t el;
    tile_t et;
    if (!rst) begin
      if (gen_enable && !ge_prev) begin
        load_cnt++;
        if (exp_load.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          el = exp_load.pop_front();
          chk("load_col_start", int'(gen_bram_col_start_index), el.cs);
          chk("load_row_start", int'(gen_bram_row_start_index), el.rs);
          chk("load_col_size",  int'(gen_col_size), el.csz);
          chk("load_row_size",  int'(gen_row_size), el.rsz);
          chk("load_bram_col",  int'(gen_bram_col_size), el.bc);
          chk("load_bram_row",  int'(gen_bram_row_size), el.br);
          chk("load_addr",      int'(gen_w_ram_start_addr), el.addr);
          chk("load_ws_os",     int'(gen_ws_os), el.ws);
        end
      end
      if (tile_valid && tile_ready) begin
        if (exp_tile.size() == 0) begin
          chk("unexpected_tile", 1, 0);
        end else begin
          et = exp_tile.pop_front();
          chk("tile_bank",     int'(tile_bank), et.bank);
          chk("tile_col_size", int'(tile_col_size), et.csz);
          chk("tile_row_size", int'(tile_row_size), et.rsz);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_with_done", int'(busy), 0);
        chk("done_single_pulse", int'(done_prev), 0);
      end
    end
    ge_prev   = gen_enable;
    done_prev = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input int cs, input int rs, input int csz, input int rsz,
                           input int bc, input int br, input int addr, input int ws);
    load_t l;
    l.cs = cs; l.rs = rs; l.csz = csz; l.rsz = rsz;
    l.bc = bc; l.br = br; l.addr = addr; l.ws = ws;
    exp_load.push_back(l);
  endtask

  task automatic push_tile(input int bank, input int csz, input int rsz);
    tile_t t;
    t.bank = bank; t.csz = csz; t.rsz = rsz;
    exp_tile.push_back(t);
  endtask

  task automatic push_8x8(input int ws);
    push_load(0, 0, 4, 4, 8, 8, 0,  ws);
    push_load(0, 4, 4, 4, 8, 8, 64, ws);
    push_load(4, 0, 4, 4, 8, 8, 0,  ws);
    push_load(4, 4, 4, 4, 8, 8, 64, ws);
  endtask

  task automatic do_start(input logic ws, input int c, input int r);
    step();
    ws_os        = ws;
    mat_col_size = IB'(c);
    mat_row_size = IB'(r);
    start        = 1'b1;
    start_cyc    = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, done_cnt - d0, 1);
  endtask

  task automatic wait_loads(input string name, input int target, input int budget);
    int i = 0;
    while (!(load_cnt >= target && gen_enable) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, (load_cnt >= target) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gen_enable", int'(gen_enable), 0);
    chk("rst_busy",       int'(busy), 0);
    chk("rst_done",       int'(done), 0);
    chk("rst_tile_valid", int'(tile_valid), 0);
    chk("rst_tile_bank",  int'(tile_bank), 0);
    chk("rst_tile_col",   int'(tile_col_size), 0);
    chk("rst_addr",       int'(gen_w_ram_start_addr), 0);
    chk("rst_gen_col",    int'(gen_col_size), 0);
    step();
    rst = 1'b0;

    // 8x8 matrix, free-running consumer.
    tile_ready = 1'b1;
    push_8x8(1);
    push_tile(0, 4, 4); push_tile(1, 4, 4); push_tile(0, 4, 4); push_tile(1, 4, 4);
    do_start(1'b1, 8, 8);
    wait_done("t1_done", 300);
    repeat (5) step();
    chk("t1_load_q_empty", exp_load.size(), 0);
    chk("t1_tile_q_empty", exp_tile.size(), 0);
    chk("t1_one_done", done_cnt, 1);

    // 6 cols x 5 rows: edge tiles shrink.
    push_load(0, 0, 4, 4, 6, 5, 0,  0);
    push_load(0, 4, 4, 1, 6, 5, 64, 0);
    push_load(4, 0, 2, 4, 6, 5, 0,  0);
    push_load(4, 4, 2, 1, 6, 5, 64, 0);
    push_tile(0, 4, 4); push_tile(1, 4, 1); push_tile(0, 2, 4); push_tile(1, 2, 1);
    do_start(1'b0, 6, 5);
    wait_done("t2_done", 300);
    chk("t2_load_q_empty", exp_load.size(), 0);
    chk("t2_tile_q_empty", exp_tile.size(), 0);

    // Consumer stalled: two banks fill, then one ready pulse frees exactly one load.
    tile_ready = 1'b0;
    l0 = load_cnt;
    push_8x8(0);
    push_tile(0, 4, 4); push_tile(1, 4, 4); push_tile(0, 4, 4); push_tile(1, 4, 4);
    do_start(1'b0, 8, 8);
    repeat (30) step();
    chk("t3_two_loads",      load_cnt - l0, 2);
    chk("t3_hold_gen_en",    int'(gen_enable), 0);
    chk("t3_hold_busy",      int'(busy), 1);
    chk("t3_hold_valid",     int'(tile_valid), 1);
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    repeat (20) step();
    chk("t3_three_loads",    load_cnt - l0, 3);
    chk("t3_hold2_gen_en",   int'(gen_enable), 0);
    chk("t3_rd_bank_moved",  int'(tile_bank), 1);
    tile_ready = 1'b1;
    wait_done("t3_done", 300);
    chk("t3_load_q_empty", exp_load.size(), 0);
    chk("t3_tile_q_empty", exp_tile.size(), 0);

    // Zero-sized matrix: done two cycles after start, no load.
    l0 = load_cnt;
    do_start(1'b0, 0, 8);
    wait_done("t4_done", 20);
    chk("t4_done_latency", done_cyc - start_cyc, 2);
    chk("t4_no_load", load_cnt - l0, 0);

    // Reset during the second load, with bank 0 still full.
    tile_ready = 1'b0;
    l0 = load_cnt;
    push_8x8(0);
    do_start(1'b0, 8, 8);
    wait_loads("t5_reach_load2", l0 + 2, 100);
    rst = 1'b1;
    #1;
    chk("t5_rst_gen_enable", int'(gen_enable), 0);
    chk("t5_rst_tile_valid", int'(tile_valid), 0);
    chk("t5_rst_busy",       int'(busy), 0);
    exp_load.delete();
    exp_tile.delete();
    step();
    step();
    rst = 1'b0;
    tile_ready = 1'b1;
    push_8x8(1);
    push_tile(0, 4, 4); push_tile(1, 4, 4); push_tile(0, 4, 4); push_tile(1, 4, 4);
    do_start(1'b1, 8, 8);
    wait_done("t5_clean_done", 300);
    chk("t5_load_q_empty", exp_load.size(), 0);
    chk("t5_tile_q_empty", exp_tile.size(), 0);

    // A second start with different sizes mid-job is ignored.
    l0 = load_cnt;
    push_8x8(1);
    push_tile(0, 4, 4); push_tile(1, 4, 4); push_tile(0, 4, 4); push_tile(1, 4, 4);
    do_start(1'b1, 8, 8);
    wait_loads("t6_reach_load2", l0 + 2, 100);
    step();
    ws_os        = 1'b0;
    mat_col_size = IB'(6);
    mat_row_size = IB'(5);
    start        = 1'b1;
    step();
    start = 1'b0;
    wait_done("t6_done", 300);
    repeat (10) step();
    chk("t6_four_loads",   load_cnt - l0, 4);
    chk("t6_idle_after",   int'(busy), 0);
    chk("t6_load_q_empty", exp_load.size(), 0);
    chk("t6_tile_q_empty", exp_tile.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w_tile_scheduler.md
W_TILE_SCHEDULER -- requirements
Module: w_tile_scheduler

Interface
REQ-001 The block SHALL have parameter INTEGER_BIT, default 7, giving the width of all size and index fields.
REQ-002 The block SHALL have parameter W_RAM_ADDR_WIDTH, default 7, giving the w_ram address width.
REQ-003 The block SHALL have parameter TILE_COLS, default 8, giving the maximum tile column count (array height).
REQ-004 The block SHALL have parameter TILE_ROWS, default 8, giving the maximum tile row count (array width).
REQ-005 The block SHALL have parameter BANK_OFFSET, default 2**(W_RAM_ADDR_WIDTH-1), giving the w_ram base address of bank 1.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-007 The block SHALL have these control ports: start (in, 1, one-cycle job request), ws_os (in, 1, dataflow mode, latched at start), mat_col_size and mat_row_size (in, INTEGER_BIT each, weight matrix dimensions in BRAM), busy (out, 1), done (out, 1, one-cycle pulse).
REQ-008 The block SHALL have these generator-side ports: gen_enable (out, 1), gen_finish (in, 1), gen_ws_os (out, 1), gen_col_size, gen_row_size, gen_bram_col_size, gen_bram_row_size, gen_bram_col_start_index and gen_bram_row_start_index (out, INTEGER_BIT each), and gen_w_ram_start_addr (out, W_RAM_ADDR_WIDTH).
REQ-009 The block SHALL have these compute-side ports: tile_valid (out, 1), tile_ready (in, 1), tile_bank (out, 1), and tile_col_size and tile_row_size (out, INTEGER_BIT each).

Function
REQ-010 The FSM SHALL use the states IDLE, LOAD, RELEASE, ADVANCE, WAIT_BANK and DRAIN.
REQ-011 In IDLE, start SHALL latch ws_os, mat_col_size and mat_row_size, clear the tile indices col_idx and row_idx, and go to DRAIN if either dimension is 0, otherwise to WAIT_BANK.
REQ-012 WAIT_BANK SHALL go to LOAD in the cycle after bank_full[wr_bank] reads 0, and SHALL otherwise hold.
REQ-013 gen_enable SHALL be 1 only in LOAD, and LOAD SHALL hold until gen_finish is 1.
REQ-014 On gen_finish in LOAD, the block SHALL set bank_full[wr_bank], store that tile's sizes for the bank, toggle wr_bank, and go to RELEASE.
REQ-015 RELEASE SHALL last exactly one cycle with gen_enable=0, so the generator clears its counter, and SHALL then go to ADVANCE.
REQ-016 ADVANCE SHALL update the tile indices row-major: row_idx += TILE_ROWS; when row_idx+TILE_ROWS >= mat_row_size, row_idx SHALL go to 0 and col_idx += TILE_COLS.
REQ-017 After ADVANCE, if the last tile has been loaded the FSM SHALL go to DRAIN, otherwise to WAIT_BANK.
REQ-018 gen_col_size SHALL equal min(TILE_COLS, mat_col_size-col_idx), and gen_row_size SHALL equal min(TILE_ROWS, mat_row_size-row_idx).
REQ-019 gen_bram_col_size and gen_bram_row_size SHALL equal the latched matrix sizes.
REQ-020 gen_bram_col_start_index SHALL equal col_idx, and gen_bram_row_start_index SHALL equal row_idx.
REQ-021 gen_w_ram_start_addr SHALL be 0 when wr_bank=0 and BANK_OFFSET when wr_bank=1.
REQ-022 Index arithmetic SHALL be done at INTEGER_BIT+1 bits so that the index sum cannot wrap.
REQ-023 tile_valid SHALL equal bank_full[rd_bank]; tile_bank SHALL equal rd_bank; tile_col_size and tile_row_size SHALL be the sizes stored for rd_bank.
REQ-024 When tile_valid and tile_ready are both 1, the block SHALL clear bank_full[rd_bank] and toggle rd_bank.
REQ-025 A load-set and a consume-clear in the same cycle always hit different banks, and both SHALL take effect.
REQ-026 DRAIN SHALL wait until both banks are empty, then pulse done for one cycle and return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start SHALL be ignored whenever busy is 1.
REQ-029 A change on ws_os or the size inputs during a job SHALL have no effect on that job.

Reset
REQ-030 While rst=1, the block SHALL be in IDLE with every output at 0, bank_full=2'b00, wr_bank=0, rd_bank=0, all indices at 0, and all latched sizes at 0.
REQ-031 A reset asserted during LOAD SHALL drop gen_enable in the same cycle, asynchronously, and the partial tile SHALL be discarded.

Structure
REQ-032 The FSM state encoding and a shared min() function SHALL live in the shared package w_sched_pkg.
REQ-033 Bank occupancy and the per-bank sizes SHALL be a sub-module, w_bank_tracker: a 2-entry flag and size register file with wr/rd pointers.

Verification
REQ-034 The bench SHALL check: TILE 4x4, mat 8x8, tile_ready=1 -> starts (0,0),(0,4),(4,0),(4,4), gen_w_ram_start_addr 0,64,0,64, then one done pulse.
REQ-035 The bench SHALL check: mat 6x5, TILE 4x4 -> tile sizes (4,4),(4,1),(2,4),(2,1).
REQ-036 The bench SHALL check: tile_ready=0 -> 2 tiles load, then the FSM holds in WAIT_BANK with gen_enable=0; one tile_ready pulse releases exactly one load.
REQ-037 The bench SHALL check: mat_col_size=0 -> done exactly 2 cycles after start with no gen_enable, and busy falls with done.
REQ-038 The bench SHALL check: rst asserted in LOAD -> gen_enable=0, tile_valid=0 and busy=0 immediately; a new start runs a clean job from (0,0).
REQ-039 The bench SHALL check: start pulsed again mid-job with a different mat size -> no effect; the original tile sequence completes.
